cache_line_xfer: RTL

- Line-transfer engine directly downstream of the direct-mapped cache controller FSM, between that FSM and the four-bank main memory.
- On a miss the controller hands it one line operation: writeback of a dirty victim, refill of the requested line, or both. The engine sequences all word-level memory requests and cache word writes.
- Tracks in-flight reads through a latency pipe so requests and returns overlap.
- Signals completion to the controller.

---
 rtl/cache_line_xfer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cache_line_xfer.sv
// Line-transfer engine between the cache controller FSM and four-bank main memory.
// Sequences a victim writeback and/or a line refill word by word, overlapping
// read requests with their returns through a fixed-latency tracking pipe.
module cache_line_xfer #(
  parameter int MEM_LAT = 2,
  parameter int WORDS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        do_wb,
  input  logic        do_fill,
  input  logic [12:0] line_addr,
  input  logic [4:0]  wb_tag,
  input  logic [15:0] cache_data_in,
  input  logic [15:0] mem_data_in,
  input  logic        mem_stall,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  cache_offset,
  output logic        cache_wr,
  output logic [15:0] cache_data_out,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(WORDS);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WB         = 3'd1;
  localparam logic [2:0] S_FILL_REQ   = 3'd2;
  localparam logic [2:0] S_FILL_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    tag_q;
  logic [7:0]    index_q;
  logic [4:0]    wb_tag_q;
  logic          fill_q;

  // Stage 0 takes the newest request, stage MEM_LAT-1 lines up with mem_data_in.
  logic [MEM_LAT-1:0] pipe_v_q;
  logic [2:0]         pipe_off_q [MEM_LAT];

  logic       push_v;
  logic [2:0] word_off;
  logic       last_word;
  logic       out_v;
  logic       older_v;
  logic       filling;

  assign word_off  = 3'({cnt_q, 1'b0});
  assign last_word = (cnt_q == CW'(WORDS - 1));
  assign out_v     = pipe_v_q[MEM_LAT-1];
  assign filling   = (state_q == S_FILL_REQ) || (state_q == S_FILL_DRAIN);
  assign busy      = (state_q != S_IDLE);

  // Any valid entry still behind the one leaving the pipe.
  always_comb begin
    older_v = 1'b0;
    for (int i = 0; i < MEM_LAT - 1; i++) older_v = older_v | pipe_v_q[i];
  end

  // Next-state, counter and all request/cache-write outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    push_v         = 1'b0;
    mem_addr       = 16'h0;
    mem_data_out   = 16'h0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    cache_offset   = 3'h0;
    cache_wr       = 1'b0;
    cache_data_out = 16'h0;
    done           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (do_wb)        state_d = S_WB;
          else if (do_fill) state_d = S_FILL_REQ;
          else              state_d = S_DONE;
        end
      end
      S_WB: begin
        mem_wr       = 1'b1;
        mem_addr     = {wb_tag_q, index_q, word_off};
        cache_offset = word_off;
        mem_data_out = cache_data_in;
        if (!mem_stall) begin
          cnt_d = cnt_q + CW'(1);
          if (last_word) state_d = fill_q ? S_FILL_REQ : S_DONE;
        end
      end
      S_FILL_REQ: begin
        mem_rd   = 1'b1;
        mem_addr = {tag_q, index_q, word_off};
        if (!mem_stall) begin
          push_v = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (last_word) state_d = S_FILL_DRAIN;
        end
      end
      S_FILL_DRAIN: begin
        if (out_v && !older_v) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Returning read data is the only cache user during a fill.
    if (filling && out_v) begin
      cache_wr       = 1'b1;
      cache_offset   = pipe_off_q[MEM_LAT-1];
      cache_data_out = mem_data_in;
    end
  end

  // State, word counter and operands latched at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tag_q    <= '0;
      index_q  <= '0;
      wb_tag_q <= '0;
      fill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && start) begin
        tag_q    <= line_addr[12:8];
        index_q  <= line_addr[7:0];
        wb_tag_q <= wb_tag;
        fill_q   <= do_fill;
      end
    end
  end

  // Read-latency pipe: shifts every fill cycle, empty otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_off_q[i] <= '0;
    end else if (filling) begin
      pipe_v_q[0]   <= push_v;
      pipe_off_q[0] <= word_off;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_off_q[i] <= pipe_off_q[i-1];
      end
    end else begin
      pipe_v_q <= '0;
    end
  end

endmodule
